// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit.
// Contents: CSR address map, exception and interrupt cause codes,
// mstatus/mie/mip bit positions, FSM state encoding and small CSR field structs.
package csr_trap_unit_pkg;

  // Low counter half is always a full 32-bit CSR.
  localparam int unsigned CNT_LO_W = 32;
  localparam int unsigned CAUSE_W  = 4;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // Cause codes
  localparam logic [CAUSE_W-1:0] EXC_ILLEGAL = 4'd2;
  localparam logic [CAUSE_W-1:0] EXC_EBREAK  = 4'd3;
  localparam logic [CAUSE_W-1:0] EXC_ECALL   = 4'd11;
  localparam logic [CAUSE_W-1:0] INT_TIMER   = 4'd7;
  localparam logic [CAUSE_W-1:0] INT_EXT     = 4'd11;

  // Bit positions inside mstatus / mie / mip
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MIE_MTIE_BIT     = 7;
  localparam int unsigned MIE_MEIE_BIT     = 11;
  localparam int unsigned MIP_MTIP_BIT     = 7;
  localparam int unsigned MIP_MEIP_BIT     = 11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  typedef struct packed {
    logic meie;
    logic mtie;
  } mie_t;

endpackage

// File: rtl/csr_trap_unit_counter.sv
// csr_counter: CNT_WIDTH free-running counter with per-half CSR write ports.
// Ports: clk_i, rst_i (sync, active-low), incr_i (count enable),
//        we_lo_i / we_hi_i (replace low/high half with wdata_i),
//        wdata_i (32-bit write data), value_o (registered count).
// A write to either half suppresses the increment for that cycle.
module csr_counter
  import csr_trap_unit_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 incr_i,
  input  logic                 we_lo_i,
  input  logic                 we_hi_i,
  input  logic [CNT_LO_W-1:0]  wdata_i,
  output logic [CNT_WIDTH-1:0] value_o
);

  localparam int unsigned HI_W = CNT_WIDTH - CNT_LO_W;

  logic [CNT_WIDTH-1:0] value_n;

  // Next count: increment unless software is overwriting a half.
  always_comb begin
    value_n = value_o + CNT_WIDTH'(incr_i);
    if (we_lo_i || we_hi_i) begin
      value_n = value_o;
    end
    if (we_lo_i) begin
      value_n[CNT_LO_W-1:0] = wdata_i;
    end
    if (we_hi_i) begin
      value_n[CNT_WIDTH-1:CNT_LO_W] = wdata_i[HI_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      value_o <= '0;
    end else begin
      value_o <= value_n;
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with counters, trap entry, MRET and
// timer/external interrupts. Issues a one-cycle redirect on every trap/return.
// Ports: clk_i, rst_i (sync, active-low);
//        raddr_i/rdata_o  exe-stage combinational read (with wb write bypass);
//        we_i/waddr_i/wdata_i  wb-stage CSR write;
//        instret_incr_i   retire strobe for minstret;
//        exc_i/exc_cause_i/exc_pc_i, mret_i  wb-stage trap events;
//        irq_timer_i/irq_ext_i  level interrupt lines;
//        redirect_o/redirect_pc_o  registered flush pulse and target PC.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH     = 32,
  parameter int unsigned          CSR_ADDR_WIDTH = 12,
  parameter int unsigned          CNT_WIDTH      = 64,
  parameter logic [DATA_WIDTH-1:0] MTVEC_RESET   = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CSR_ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  input  logic                      we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      instret_incr_i,
  input  logic                      exc_i,
  input  logic [3:0]                exc_cause_i,
  input  logic [DATA_WIDTH-1:0]     exc_pc_i,
  input  logic                      mret_i,
  input  logic                      irq_timer_i,
  input  logic                      irq_ext_i,
  output logic                      redirect_o,
  output logic [DATA_WIDTH-1:0]     redirect_pc_o
);

  localparam int unsigned CNT_HI_W = CNT_WIDTH - CNT_LO_W;
  localparam logic [DATA_WIDTH-1:0] LOW2_MASK = ~DATA_WIDTH'(3);

  localparam logic [CSR_ADDR_WIDTH-1:0] A_MSTATUS   = CSR_ADDR_WIDTH'(CSR_MSTATUS);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MIE       = CSR_ADDR_WIDTH'(CSR_MIE);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MTVEC     = CSR_ADDR_WIDTH'(CSR_MTVEC);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MEPC      = CSR_ADDR_WIDTH'(CSR_MEPC);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MCAUSE    = CSR_ADDR_WIDTH'(CSR_MCAUSE);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MIP       = CSR_ADDR_WIDTH'(CSR_MIP);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MCYCLE    = CSR_ADDR_WIDTH'(CSR_MCYCLE);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MINSTRET  = CSR_ADDR_WIDTH'(CSR_MINSTRET);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MCYCLEH   = CSR_ADDR_WIDTH'(CSR_MCYCLEH);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MINSTRETH = CSR_ADDR_WIDTH'(CSR_MINSTRETH);

  state_e                state_q, state_n;
  mstatus_t              mstatus_q;
  mie_t                  mie_q;
  logic [DATA_WIDTH-1:0] mtvec_q;
  logic [DATA_WIDTH-1:0] mepc_q;
  logic [DATA_WIDTH-1:0] mcause_q;
  logic [CNT_WIDTH-1:0]  mcycle_val;
  logic [CNT_WIDTH-1:0]  minstret_val;

  logic                  redirect_n;
  logic [DATA_WIDTH-1:0] redirect_pc_n;
  logic                  take_exc, take_mret, take_int;
  logic                  int_req;
  logic [3:0]            int_cause;
  logic [DATA_WIDTH-1:0] mtvec_base;
  logic [DATA_WIDTH-1:0] mcause_trap;
  logic [DATA_WIDTH-1:0] view_data;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ok;

  // Write-port decode
  logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;
  logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  assign wr_mstatus   = we_i && (waddr_i == A_MSTATUS);
  assign wr_mie       = we_i && (waddr_i == A_MIE);
  assign wr_mtvec     = we_i && (waddr_i == A_MTVEC);
  assign wr_mepc      = we_i && (waddr_i == A_MEPC);
  assign wr_mcause    = we_i && (waddr_i == A_MCAUSE);
  assign wr_mcycle    = we_i && (waddr_i == A_MCYCLE);
  assign wr_mcycleh   = we_i && (waddr_i == A_MCYCLEH);
  assign wr_minstret  = we_i && (waddr_i == A_MINSTRET);
  assign wr_minstreth = we_i && (waddr_i == A_MINSTRETH);

  // Storage form of a write: field masks, mtvec mode legalisation, mepc alignment.
  // wr_ok flags addresses that actually hold state (eligible for bypass).
  always_comb begin
    wr_data = '0;
    wr_ok   = 1'b1;
    case (waddr_i)
      A_MSTATUS: begin
        wr_data[MSTATUS_MIE_BIT]  = wdata_i[MSTATUS_MIE_BIT];
        wr_data[MSTATUS_MPIE_BIT] = wdata_i[MSTATUS_MPIE_BIT];
      end
      A_MIE: begin
        wr_data[MIE_MTIE_BIT] = wdata_i[MIE_MTIE_BIT];
        wr_data[MIE_MEIE_BIT] = wdata_i[MIE_MEIE_BIT];
      end
      A_MTVEC: begin
        // Modes 2/3 are reserved and collapse to direct.
        wr_data    = wdata_i & LOW2_MASK;
        wr_data[0] = (wdata_i[1:0] == 2'b01);
      end
      A_MEPC:                  wr_data = wdata_i & LOW2_MASK;
      A_MCAUSE:                wr_data = wdata_i;
      A_MCYCLE, A_MINSTRET:    wr_data = DATA_WIDTH'(wdata_i[CNT_LO_W-1:0]);
      A_MCYCLEH, A_MINSTRETH:  wr_data = DATA_WIDTH'(wdata_i[CNT_HI_W-1:0]);
      default:                 wr_ok   = 1'b0;
    endcase
  end

  // Architectural read view of the stored state.
  always_comb begin
    view_data = '0;
    case (raddr_i)
      A_MSTATUS: begin
        view_data[MSTATUS_MIE_BIT]  = mstatus_q.mie;
        view_data[MSTATUS_MPIE_BIT] = mstatus_q.mpie;
      end
      A_MIE: begin
        view_data[MIE_MTIE_BIT] = mie_q.mtie;
        view_data[MIE_MEIE_BIT] = mie_q.meie;
      end
      A_MTVEC:     view_data = mtvec_q;
      A_MEPC:      view_data = mepc_q;
      A_MCAUSE:    view_data = mcause_q;
      A_MIP: begin
        view_data[MIP_MTIP_BIT] = irq_timer_i;
        view_data[MIP_MEIP_BIT] = irq_ext_i;
      end
      A_MCYCLE:    view_data = DATA_WIDTH'(mcycle_val[CNT_LO_W-1:0]);
      A_MCYCLEH:   view_data = DATA_WIDTH'(mcycle_val[CNT_WIDTH-1:CNT_LO_W]);
      A_MINSTRET:  view_data = DATA_WIDTH'(minstret_val[CNT_LO_W-1:0]);
      A_MINSTRETH: view_data = DATA_WIDTH'(minstret_val[CNT_WIDTH-1:CNT_LO_W]);
      default:     view_data = '0;
    endcase
  end

  // Exe read with same-cycle wb bypass.
  always_comb begin
    rdata_o = view_data;
    if (we_i && wr_ok && (waddr_i == raddr_i)) begin
      rdata_o = wr_data;
    end
  end

  // Interrupt arbitration: external beats timer.
  assign int_req    = mstatus_q.mie &&
                      ((mie_q.meie && irq_ext_i) || (mie_q.mtie && irq_timer_i));
  assign int_cause  = (mie_q.meie && irq_ext_i) ? INT_EXT : INT_TIMER;
  assign mtvec_base = mtvec_q & LOW2_MASK;

  always_comb begin
    mcause_trap                 = '0;
    mcause_trap[DATA_WIDTH-1]   = take_int;
    mcause_trap[3:0]            = take_int ? int_cause : exc_cause_i;
  end

  // Next-state / redirect logic; events are only accepted in IDLE.
  always_comb begin
    state_n       = state_q;
    redirect_n    = 1'b0;
    redirect_pc_n = redirect_pc_o;
    take_exc      = 1'b0;
    take_mret     = 1'b0;
    take_int      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exc_i) begin
          take_exc = 1'b1;
        end else if (mret_i) begin
          take_mret = 1'b1;
        end else if (int_req) begin
          take_int = 1'b1;
        end
        if (take_exc || take_mret || take_int) begin
          state_n    = ST_FLUSH;
          redirect_n = 1'b1;
        end
        if (take_exc) begin
          redirect_pc_n = mtvec_base;
        end else if (take_mret) begin
          redirect_pc_n = mepc_q;
        end else if (take_int) begin
          redirect_pc_n = mtvec_q[0] ? mtvec_base + (DATA_WIDTH'(int_cause) << 2)
                                     : mtvec_base;
        end
      end
      ST_FLUSH: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_IDLE;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      state_q       <= state_n;
      redirect_o    <= redirect_n;
      redirect_pc_o <= redirect_pc_n;
    end
  end

  // CSR storage; trap/MRET updates are placed last so they override software writes.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mstatus_q <= '0;
      mie_q     <= '0;
      mtvec_q   <= MTVEC_RESET;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      if (wr_mstatus) begin
        mstatus_q.mie  <= wdata_i[MSTATUS_MIE_BIT];
        mstatus_q.mpie <= wdata_i[MSTATUS_MPIE_BIT];
      end
      if (wr_mie) begin
        mie_q.mtie <= wdata_i[MIE_MTIE_BIT];
        mie_q.meie <= wdata_i[MIE_MEIE_BIT];
      end
      if (wr_mtvec)  mtvec_q  <= wr_data;
      if (wr_mepc)   mepc_q   <= wr_data;
      if (wr_mcause) mcause_q <= wr_data;

      if (take_exc || take_int) begin
        mepc_q         <= exc_pc_i & LOW2_MASK;
        mcause_q       <= mcause_trap;
        mstatus_q.mpie <= mstatus_q.mie;
        mstatus_q.mie  <= 1'b0;
      end
      if (take_mret) begin
        mstatus_q.mie  <= mstatus_q.mpie;
        mstatus_q.mpie <= 1'b1;
      end
    end
  end

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .incr_i  (1'b1),
    .we_lo_i (wr_mcycle),
    .we_hi_i (wr_mcycleh),
    .wdata_i (wdata_i[CNT_LO_W-1:0]),
    .value_o (mcycle_val)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .incr_i  (instret_incr_i),
    .we_lo_i (wr_minstret),
    .we_hi_i (wr_minstreth),
    .wdata_i (wdata_i[CNT_LO_W-1:0]),
    .value_o (minstret_val)
  );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit.
module tb_csr_trap_unit;

  logic        clk_i          = 1'b0;
  logic        rst_i          = 1'b0;
  logic [11:0] raddr_i        = '0;
  logic [31:0] rdata_o;
  logic        we_i           = 1'b0;
  logic [11:0] waddr_i        = '0;
  logic [31:0] wdata_i        = '0;
  logic        instret_incr_i = 1'b0;
  logic        exc_i          = 1'b0;
  logic [3:0]  exc_cause_i    = '0;
  logic [31:0] exc_pc_i       = '0;
  logic        mret_i         = 1'b0;
  logic        irq_timer_i    = 1'b0;
  logic        irq_ext_i      = 1'b0;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  int checks = 0;
  int errors = 0;

  csr_trap_unit #(
    .DATA_WIDTH     (32),
    .CSR_ADDR_WIDTH (12),
    .CNT_WIDTH      (64),
    .MTVEC_RESET    (32'h0000_0080)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .raddr_i        (raddr_i),
    .rdata_o        (rdata_o),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .instret_incr_i (instret_incr_i),
    .exc_i          (exc_i),
    .exc_cause_i    (exc_cause_i),
    .exc_pc_i       (exc_pc_i),
    .mret_i         (mret_i),
    .irq_timer_i    (irq_timer_i),
    .irq_ext_i      (irq_ext_i),
    .redirect_o     (redirect_o),
    .redirect_pc_o  (redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    raddr_i = a;
    #1;
    chk(tag, rdata_o, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we_i    = 1'b1;
    waddr_i = a;
    wdata_i = d;
    step();
    we_i    = 1'b0;
  endtask

  initial begin
    // Reset held for two edges
    step();
    step();
    rst_i = 1'b1;
    rd("rst_mtvec", 12'h305, 32'h0000_0080);
    rd("rst_mstatus", 12'h300, 32'h0);
    rd("rst_mepc", 12'h341, 32'h0);
    rd("rst_mcycle", 12'hB00, 32'h0);
    chk("rst_redirect", {31'h0, redirect_o}, 32'h0);

    // Write bypass with illegal mode 3
    we_i = 1'b1; waddr_i = 12'h305; wdata_i = 32'h103; raddr_i = 12'h305;
    #1;
    chk("bypass_mtvec", rdata_o, 32'h100);
    step();
    we_i = 1'b0;
    rd("mtvec_stored", 12'h305, 32'h100);

    // Ecall with MIE=1
    wr(12'h300, 32'h8);
    exc_i = 1'b1; exc_cause_i = 4'd11; exc_pc_i = 32'h40;
    step();
    exc_i = 1'b0;
    chk("ecall_redirect", {31'h0, redirect_o}, 32'h1);
    chk("ecall_pc", redirect_pc_o, 32'h100);
    rd("ecall_mepc", 12'h341, 32'h40);
    rd("ecall_mcause", 12'h342, 32'h0000_000B);
    rd("ecall_mstatus", 12'h300, 32'h80);
    step();
    chk("ecall_pulse_end", {31'h0, redirect_o}, 32'h0);

    // MRET back to mepc
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    chk("mret_redirect", {31'h0, redirect_o}, 32'h1);
    chk("mret_pc", redirect_pc_o, 32'h40);
    rd("mret_mstatus", 12'h300, 32'h88);
    step();

    // Vectored timer interrupt
    wr(12'h305, 32'h201);
    wr(12'h304, 32'h80);
    exc_pc_i = 32'h64;
    irq_timer_i = 1'b1;
    step();
    chk("tmr_redirect", {31'h0, redirect_o}, 32'h1);
    chk("tmr_pc", redirect_pc_o, 32'h21C);
    rd("tmr_mcause", 12'h342, 32'h8000_0007);
    rd("tmr_mepc", 12'h341, 32'h64);
    step();

    // Timer + external pending: external wins
    irq_ext_i = 1'b1;
    wr(12'h304, 32'h880);
    wr(12'h300, 32'h8);
    step();
    chk("ext_redirect", {31'h0, redirect_o}, 32'h1);
    chk("ext_pc", redirect_pc_o, 32'h22C);
    rd("ext_mcause", 12'h342, 32'h8000_000B);
    step();

    // Exception beats pending interrupt; interrupt lines stay pending
    wr(12'h300, 32'h8);
    exc_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 32'h80;
    step();
    exc_i = 1'b0;
    chk("prio_redirect", {31'h0, redirect_o}, 32'h1);
    chk("prio_pc", redirect_pc_o, 32'h200);
    rd("prio_mcause", 12'h342, 32'h2);
    rd("prio_mip", 12'h344, 32'h880);
    rd("prio_mstatus", 12'h300, 32'h80);
    // Exception raised while in FLUSH is dropped
    exc_i = 1'b1; exc_cause_i = 4'd3; exc_pc_i = 32'hC0;
    step();
    exc_i = 1'b0;
    chk("flush_drop_redirect", {31'h0, redirect_o}, 32'h0);
    rd("flush_drop_mcause", 12'h342, 32'h2);
    rd("flush_drop_mepc", 12'h341, 32'h80);
    irq_timer_i = 1'b0; irq_ext_i = 1'b0;
    step();
    chk("no_second_redirect", {31'h0, redirect_o}, 32'h0);

    // Trap update of mcause beats a same-cycle software write
    we_i = 1'b1; waddr_i = 12'h342; wdata_i = 32'h55;
    exc_i = 1'b1; exc_cause_i = 4'd3; exc_pc_i = 32'h10;
    step();
    we_i = 1'b0; exc_i = 1'b0;
    chk("ebreak_pc", redirect_pc_o, 32'h200);
    rd("ebreak_mcause", 12'h342, 32'h3);
    rd("ebreak_mepc", 12'h341, 32'h10);
    step();

    // MRET with a same-cycle mie write: write still lands
    we_i = 1'b1; waddr_i = 12'h304; wdata_i = 32'h80;
    mret_i = 1'b1;
    step();
    we_i = 1'b0; mret_i = 1'b0;
    chk("mret2_pc", redirect_pc_o, 32'h10);
    rd("mret2_mie", 12'h304, 32'h80);
    rd("mret2_mstatus", 12'h300, 32'h80);
    step();

    // mepc alignment and unimplemented address
    wr(12'h341, 32'h123);
    rd("mepc_align", 12'h341, 32'h120);
    wr(12'h7C0, 32'hFFFF);
    rd("unimpl_read", 12'h7C0, 32'h0);

    // mcycle carry from low into high half
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    step();
    rd("mcycle_lo_wrap", 12'hB00, 32'h0);
    rd("mcycle_hi_carry", 12'hB80, 32'h1);

    // minstret only counts retire strobes
    rd("minstret_idle0", 12'hB02, 32'h0);
    step();
    rd("minstret_idle1", 12'hB02, 32'h0);
    instret_incr_i = 1'b1;
    step();
    step();
    step();
    instret_incr_i = 1'b0;
    rd("minstret_count", 12'hB02, 32'h3);
    rd("minstreth", 12'hB82, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Parametrised successor to the current CSR file. It holds the machine-mode CSRs and the counters, and adds trap entry, MRET return and timer/external interrupt handling. It sits beside the pipeline. The exe stage reads it, wb writes it, and trap/MRET/interrupt events come from the wb stage. On each trap or return it issues a one-cycle redirect to pipe_ctrl, which flushes the pipeline and loads the new PC.

Parameters:
DATA_WIDTH, 32, CSR data and PC width
CSR_ADDR_WIDTH, 12, CSR address width
CNT_WIDTH, 64, mcycle/minstret width (33..64); bits above 32 are read via the high-half CSRs, zero-extended
MTVEC_RESET, 32'h0, reset value of mtvec

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-low
raddr_i  in  CSR_ADDR_WIDTH  exe read address
rdata_o  out  DATA_WIDTH  combinational read data
we_i  in  1  wb CSR write enable
waddr_i  in  CSR_ADDR_WIDTH  wb write address
wdata_i  in  DATA_WIDTH  wb write data
instret_incr_i  in  1  one instruction retired this cycle
exc_i  in  1  synchronous exception at wb (ecall/ebreak/illegal)
exc_cause_i  in  4  exception code
exc_pc_i  in  DATA_WIDTH  PC of the excepting instruction; also the interrupt return PC
mret_i  in  1  MRET retiring at wb
irq_timer_i  in  1  level timer interrupt
irq_ext_i  in  1  level external interrupt
redirect_o  out  1  one-cycle flush/redirect pulse to pipe_ctrl
redirect_pc_o  out  DATA_WIDTH  target PC, valid while redirect_o=1

Behaviour:
- Reset (rst_i=0 at clk edge): mstatus.MIE=0, MPIE=0; mie=0; mepc=0; mcause=0; mtvec=MTVEC_RESET; counters=0; FSM=IDLE; redirect_o=0; redirect_pc_o=0. Reset during FLUSH aborts the redirect.
- CSR map: mstatus 0x300 (MIE bit3, MPIE bit7, rest read 0), mie 0x304 (MTIE bit7, MEIE bit11), mtvec 0x305, mepc 0x341 (bits[1:0] forced 0), mcause 0x342, mip 0x344 (read-only: MTIP=irq_timer_i, MEIP=irq_ext_i).
- Counter CSRs: mcycle 0xB00/0xB80, minstret 0xB02/0xB82 (low/high halves).
- Unimplemented addresses read 0; writes to them are ignored.
- Read is combinational. Write bypass: if we_i and waddr_i==raddr_i, rdata_o=wdata_i (masked as for storage).
- mtvec.MODE[1:0]: 0 selects direct, 1 selects vectored; a write of 2 or 3 stores 0. Base is bits[31:2].
- mcycle: +1 every cycle. minstret: +instret_incr_i.
- A CSR write to a half replaces that half this cycle and suppresses the increment for that counter. The low half carries into the high half; the counter wraps at 2^CNT_WIDTH.
- Interrupt pending: int_req = MIE & ((MEIE&irq_ext_i) | (MTIE&irq_timer_i)). External (cause 11) beats timer (cause 7).
- Event priority in IDLE: exc_i > mret_i > int_req.
- FSM, IDLE -> FLUSH on any event. At that edge:
  - Exception: mepc=exc_pc_i; mcause={0,cause}; MPIE=MIE; MIE=0; target=mtvec base.
  - Interrupt: mepc=exc_pc_i; mcause={1,cause}; MPIE=MIE; MIE=0; target=base, or base+4*cause when vectored.
  - MRET: MIE=MPIE; MPIE=1; target=mepc.
- FLUSH: redirect_o=1 and redirect_pc_o=target for exactly one cycle. exc_i/mret_i/int_req are ignored in this state. FLUSH -> IDLE unconditionally.
- Latency: event sampled at edge N; redirect_o high during cycle N+1.
- A CSR write in the same cycle as an event: trap/MRET updates to mstatus/mepc/mcause win; writes to other CSRs apply normally.
- Writes during FLUSH apply normally.

Decomposition:
- Add to defines.v: CSR address constants, cause codes (EXC_ECALL=11, EXC_EBREAK=3, EXC_ILLEGAL=2, INT_TIMER=7, INT_EXT=11), mstatus/mie bit positions, FSM state encodings.
- One sub-module, csr_counter: CNT_WIDTH counter with increment enable and low/high half write ports. Instantiated twice (mcycle, minstret).

Test Plan:
- Reset: hold rst_i=0 for 2 cycles -> reading 0x305 gives MTVEC_RESET; 0x300, 0x341, 0xB00 read 0; redirect_o=0.
- Bypass: we_i=1, waddr=raddr=0x305, wdata=0x103 in the same cycle -> rdata_o=0x100; next cycle reads 0x100.
- Ecall: mtvec=0x100, MIE=1; exc_i with cause 11, pc 0x40 -> next cycle redirect_o=1 and pc=0x100; mepc=0x40, mcause=0x0000000B, mstatus=0x80.
- Then mret_i -> next cycle redirect_pc_o=0x40 and mstatus=0x88.
- Vectored timer: mtvec=0x201, mie=0x80, MIE=1, irq_timer_i=1 -> redirect_pc_o=0x21C, mcause=0x80000007.
- Timer+ext both pending with MEIE=1 -> mcause=0x8000000B, redirect_pc_o=0x22C.
- Priority/drop: exc_i and int_req asserted together -> exception taken, and interrupt state remains pending. Assert exc_i during FLUSH -> ignored, no second redirect.
- Counter carry: write 0xB00=0xFFFFFFFF and 0xB80=0 -> two cycles later 0xB80 reads 1, 0xB00 reads 0x00000000. minstret is unchanged when instret_incr_i=0.
